// File: rtl/lif_pkg.sv
// Shared definitions for the LIF neuron layer: FSM encoding, weight polarity
// and membrane reset-mode constants.
package lif_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } lif_state_e;

  localparam logic W_POS = 1'b1;
  localparam logic W_NEG = 1'b0;

  localparam logic RM_ZERO = 1'b0;
  localparam logic RM_SUB  = 1'b1;

endpackage

// File: rtl/lif_neuron_core.sv
// Combinational single-neuron update: binary-weight popcount, leak shifter,
// saturating integrate, threshold compare and refractory handling.
module lif_neuron_core
  import lif_pkg::*;
#(
  parameter int unsigned N_INPUTS = 8,
  parameter int unsigned MEM_W    = 6,
  parameter int unsigned THR_W    = MEM_W - 1,
  parameter int unsigned REF_W    = 3
) (
  input  logic [MEM_W-1:0]    u_i,
  input  logic [REF_W-1:0]    c_i,
  input  logic [N_INPUTS-1:0] weights_i,
  input  logic [N_INPUTS-1:0] inputs_i,
  input  logic [THR_W-1:0]    threshold_i,
  input  logic [2:0]          shift_i,
  input  logic [REF_W-1:0]    refractory_i,
  input  logic                reset_mode_i,
  output logic [MEM_W-1:0]    u_o,
  output logic [REF_W-1:0]    c_o,
  output logic                spike_o
);

  // Two guard bits keep d + psp exact before clamping back to MEM_W.
  localparam int unsigned ACC_W = MEM_W + 2;
  localparam logic signed [ACC_W-1:0] MAX_V = {3'b000, {(MEM_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] MIN_V = {3'b111, {(MEM_W-1){1'b0}}};

  logic signed [ACC_W-1:0] psp;
  logic signed [ACC_W-1:0] u_ext;
  logic signed [ACC_W-1:0] d;
  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] sat;
  logic signed [ACC_W-1:0] th_ext;
  logic        [MEM_W-1:0] sub;

  always_comb begin
    psp = '0;
    for (int i = 0; i < N_INPUTS; i++) begin
      if (inputs_i[i]) begin
        psp = (weights_i[i] == W_POS) ? psp + ACC_W'(1) : psp - ACC_W'(1);
      end
    end

    u_ext = ACC_W'(signed'(u_i));
    d     = (shift_i == 3'd0) ? u_ext : u_ext - (u_ext >>> shift_i);
    acc   = d + psp;

    if (acc > MAX_V)      sat = MAX_V;
    else if (acc < MIN_V) sat = MIN_V;
    else                  sat = acc;

    th_ext = ACC_W'({1'b0, threshold_i});
    // sat >= th >= 0 whenever this is used, so it never wraps.
    sub    = sat[MEM_W-1:0] - MEM_W'(threshold_i);

    u_o     = u_i;
    c_o     = c_i;
    spike_o = 1'b0;
    if (c_i != '0) begin
      u_o = d[MEM_W-1:0];
      c_o = c_i - REF_W'(1);
    end else if (sat >= th_ext) begin
      spike_o = 1'b1;
      c_o     = refractory_i;
      u_o     = (reset_mode_i == RM_SUB) ? sub : '0;
    end else begin
      u_o = sat[MEM_W-1:0];
    end
  end

endmodule

// File: rtl/lif_neuron_layer.sv
// Layer of LIF neurons sharing one lif_neuron_core, stepped one neuron per
// cycle; holds per-neuron state, configuration and the step FSM.
module lif_neuron_layer
  import lif_pkg::*;
#(
  parameter int unsigned N_INPUTS  = 8,
  parameter int unsigned N_NEURONS = 4,
  parameter int unsigned MEM_W     = 6,
  parameter int unsigned THR_W     = MEM_W - 1,
  parameter int unsigned REF_W     = 3
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         cfg_we,
  input  logic [$clog2(N_NEURONS)-1:0] cfg_addr,
  input  logic [N_INPUTS-1:0]          cfg_weights,
  input  logic [THR_W-1:0]             cfg_threshold,
  input  logic [2:0]                   shift,
  input  logic [REF_W-1:0]             refractory,
  input  logic                         reset_mode,
  input  logic                         step_valid,
  output logic                         step_ready,
  input  logic [N_INPUTS-1:0]          inputs,
  output logic                         spikes_valid,
  output logic [N_NEURONS-1:0]         spikes,
  input  logic [$clog2(N_NEURONS)-1:0] mon_addr,
  output logic [MEM_W-1:0]             mon_membrane
);

  localparam int unsigned IDX_W = $clog2(N_NEURONS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_NEURONS - 1);

  lif_state_e           state_q;
  logic [IDX_W-1:0]     idx_q;
  logic [N_INPUTS-1:0]  inputs_q;
  logic [N_NEURONS-1:0] spikes_q;
  logic                 step_ready_q;
  logic                 spikes_valid_q;

  logic [MEM_W-1:0]    mem_q [N_NEURONS];
  logic [REF_W-1:0]    ref_q [N_NEURONS];
  logic [N_INPUTS-1:0] w_q   [N_NEURONS];
  logic [THR_W-1:0]    thr_q [N_NEURONS];

  logic [MEM_W-1:0] u_d;
  logic [REF_W-1:0] c_d;
  logic             spike_d;

  lif_neuron_core #(
    .N_INPUTS(N_INPUTS),
    .MEM_W   (MEM_W),
    .THR_W   (THR_W),
    .REF_W   (REF_W)
  ) u_core (
    .u_i         (mem_q[idx_q]),
    .c_i         (ref_q[idx_q]),
    .weights_i   (w_q[idx_q]),
    .inputs_i    (inputs_q),
    .threshold_i (thr_q[idx_q]),
    .shift_i     (shift),
    .refractory_i(refractory),
    .reset_mode_i(reset_mode),
    .u_o         (u_d),
    .c_o         (c_d),
    .spike_o     (spike_d)
  );

  // Step FSM, neuron state write-back and configuration port.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= ST_IDLE;
      idx_q          <= '0;
      inputs_q       <= '0;
      spikes_q       <= '0;
      step_ready_q   <= 1'b1;
      spikes_valid_q <= 1'b0;
      for (int n = 0; n < N_NEURONS; n++) begin
        mem_q[n] <= '0;
        ref_q[n] <= '0;
        w_q[n]   <= '0;
        thr_q[n] <= '1;
      end
    end else begin
      spikes_valid_q <= 1'b0;
      if (cfg_we && step_ready_q) begin
        w_q[cfg_addr]   <= cfg_weights;
        thr_q[cfg_addr] <= cfg_threshold;
      end
      case (state_q)
        ST_IDLE: begin
          if (step_valid) begin
            inputs_q     <= inputs;
            idx_q        <= '0;
            state_q      <= ST_RUN;
            step_ready_q <= 1'b0;
          end
        end
        ST_RUN: begin
          mem_q[idx_q]    <= u_d;
          ref_q[idx_q]    <= c_d;
          spikes_q[idx_q] <= spike_d;
          if (idx_q == LAST_IDX) begin
            state_q        <= ST_DONE;
            spikes_valid_q <= 1'b1;
          end else begin
            idx_q <= idx_q + IDX_W'(1);
          end
        end
        ST_DONE: begin
          state_q      <= ST_IDLE;
          step_ready_q <= 1'b1;
        end
        default: begin
          state_q      <= ST_IDLE;
          step_ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign step_ready   = step_ready_q;
  assign spikes_valid = spikes_valid_q;
  assign spikes       = spikes_q;
  assign mon_membrane = mem_q[mon_addr];

endmodule

// File: tb/tb_lif_neuron_layer.sv
// Directed self-checking bench for lif_neuron_layer at default parameters.
module tb_lif_neuron_layer;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       cfg_we = 1'b0;
  logic [1:0] cfg_addr = '0;
  logic [7:0] cfg_weights = '0;
  logic [4:0] cfg_threshold = '0;
  logic [2:0] shift = '0;
  logic [2:0] refractory = '0;
  logic       reset_mode = 1'b0;
  logic       step_valid = 1'b0;
  logic       step_ready;
  logic [7:0] inputs = '0;
  logic       spikes_valid;
  logic [3:0] spikes;
  logic [1:0] mon_addr = '0;
  logic [5:0] mon_membrane;

  int n_checks = 0;
  int n_fail   = 0;

  localparam logic signed [5:0] NEG_EXP   [5] = '{-6'sd8, -6'sd16, -6'sd24, -6'sd32, -6'sd32};
  localparam logic signed [5:0] DECAY_EXP [5] = '{6'sd8, 6'sd4, 6'sd2, 6'sd1, 6'sd1};
  localparam logic signed [5:0] REF_MEM   [4] = '{6'sd3, 6'sd3, 6'sd3, 6'sd6};
  localparam logic        [3:0] REF_SPK   = 4'b1001;

  lif_neuron_layer dut (
    .clk          (clk),
    .reset        (reset),
    .cfg_we       (cfg_we),
    .cfg_addr     (cfg_addr),
    .cfg_weights  (cfg_weights),
    .cfg_threshold(cfg_threshold),
    .shift        (shift),
    .refractory   (refractory),
    .reset_mode   (reset_mode),
    .step_valid   (step_valid),
    .step_ready   (step_ready),
    .inputs       (inputs),
    .spikes_valid (spikes_valid),
    .spikes       (spikes),
    .mon_addr     (mon_addr),
    .mon_membrane (mon_membrane)
  );

  always #5 clk = ~clk;

  task automatic do_reset;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic do_cfg(input logic [1:0] a, input logic [7:0] w, input logic [4:0] t);
    cfg_we = 1'b1; cfg_addr = a; cfg_weights = w; cfg_threshold = t;
    @(posedge clk); #1;
    cfg_we = 1'b0;
  endtask

  // Offers one step and returns cycles from acceptance to spikes_valid (-1 on timeout).
  task automatic do_step(input logic [7:0] vec, output logic [3:0] spk, output int lat);
    int n;
    step_valid = 1'b1; inputs = vec; n = 0;
    while (!step_ready && n < 20) begin @(posedge clk); #1; n++; end
    @(posedge clk); #1;
    step_valid = 1'b0;
    lat = -1;
    for (int c = 1; c <= 20; c++) begin
      if (spikes_valid) begin lat = c; break; end
      @(posedge clk); #1;
    end
    spk = spikes;
  endtask

  task automatic test_reset;
    do_reset();
    n_checks++;
    if (step_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b expected 1", step_ready); end
    n_checks++;
    if (spikes_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", spikes_valid); end
    n_checks++;
    if (spikes !== 4'b0000) begin n_fail++; $display("FAIL reset_spikes: got %b expected 0000", spikes); end
    for (int j = 0; j < 4; j++) begin
      mon_addr = 2'(j); #1;
      n_checks++;
      if (mon_membrane !== 6'd0) begin n_fail++; $display("FAIL reset_mem%0d: got %0d expected 0", j, $signed(mon_membrane)); end
    end
  endtask

  task automatic test_basic_spike;
    logic [3:0] spk; int lat;
    do_reset();
    do_cfg(2'd0, 8'hFF, 5'd5);
    do_step(8'hFF, spk, lat);
    n_checks++;
    if (lat != 5) begin n_fail++; $display("FAIL basic_latency: got %0d expected 5", lat); end
    n_checks++;
    if (spk !== 4'b0001) begin n_fail++; $display("FAIL basic_spikes: got %b expected 0001", spk); end
    mon_addr = 2'd0; #1;
    n_checks++;
    if (mon_membrane !== 6'd0) begin n_fail++; $display("FAIL basic_mem0: got %0d expected 0", $signed(mon_membrane)); end
    mon_addr = 2'd1; #1;
    n_checks++;
    if (mon_membrane !== 6'h38) begin n_fail++; $display("FAIL basic_mem1: got %0d expected -8", $signed(mon_membrane)); end
    @(posedge clk); #1;
    n_checks++;
    if (spikes_valid !== 1'b0) begin n_fail++; $display("FAIL basic_valid_pulse: got %b expected 0", spikes_valid); end
  endtask

  task automatic test_cfg_same_edge;
    logic [3:0] spk; int lat;
    do_reset();
    cfg_we = 1'b1; cfg_addr = 2'd3; cfg_weights = 8'hFF; cfg_threshold = 5'd5;
    do_step(8'hFF, spk, lat);
    cfg_we = 1'b0;
    n_checks++;
    if (spk !== 4'b1000) begin n_fail++; $display("FAIL same_edge_cfg: got %b expected 1000", spk); end
  endtask

  task automatic test_neg_saturation;
    logic [3:0] spk; int lat;
    do_reset();
    do_cfg(2'd1, 8'h00, 5'd31);
    mon_addr = 2'd1;
    for (int s = 0; s < 5; s++) begin
      do_step(8'hFF, spk, lat);
      #1;
      n_checks++;
      if (mon_membrane !== NEG_EXP[s] || spk[1] !== 1'b0) begin
        n_fail++;
        $display("FAIL neg_sat step %0d: membrane %0d spike %b expected %0d spike 0", s, $signed(mon_membrane), spk[1], NEG_EXP[s]);
      end
    end
  endtask

  task automatic test_decay;
    logic [3:0] spk; int lat;
    do_reset();
    do_cfg(2'd2, 8'hFF, 5'd31);
    mon_addr = 2'd2;
    do_step(8'hFF, spk, lat);
    do_step(8'hFF, spk, lat);
    #1;
    n_checks++;
    if (mon_membrane !== 6'd16) begin n_fail++; $display("FAIL decay_charge: got %0d expected 16", $signed(mon_membrane)); end
    shift = 3'd1;
    for (int s = 0; s < 5; s++) begin
      do_step(8'h00, spk, lat);
      #1;
      n_checks++;
      if (mon_membrane !== DECAY_EXP[s]) begin
        n_fail++;
        $display("FAIL decay step %0d: got %0d expected %0d", s, $signed(mon_membrane), DECAY_EXP[s]);
      end
    end
    shift = 3'd0;
  endtask

  task automatic test_refractory_sub;
    logic [3:0] spk; int lat;
    do_reset();
    do_cfg(2'd0, 8'hFF, 5'd5);
    refractory = 3'd2; reset_mode = 1'b1;
    mon_addr = 2'd0;
    for (int s = 0; s < 4; s++) begin
      do_step(8'hFF, spk, lat);
      #1;
      n_checks++;
      if (spk[0] !== REF_SPK[s] || mon_membrane !== REF_MEM[s]) begin
        n_fail++;
        $display("FAIL refractory step %0d: spike %b membrane %0d expected spike %b membrane %0d",
                 s, spk[0], $signed(mon_membrane), REF_SPK[s], REF_MEM[s]);
      end
    end
    refractory = 3'd0; reset_mode = 1'b0;
  endtask

  task automatic test_back_to_back;
    int acc_t [3];
    logic [3:0] sv [2];
    int n_acc = 0;
    int nv = 0;
    do_reset();
    do_cfg(2'd0, 8'hFF, 5'd5);
    cfg_addr = 2'd0; cfg_weights = 8'h00; cfg_threshold = 5'd31;
    step_valid = 1'b1; inputs = 8'hFF;
    acc_t = '{0, 0, 0};
    sv = '{4'b0, 4'b0};
    for (int cyc = 0; cyc < 20; cyc++) begin
      cfg_we = (n_acc == 1 && cyc == acc_t[0] + 2);
      if (step_ready && n_acc < 3) begin acc_t[n_acc] = cyc; n_acc++; end
      if (spikes_valid && nv < 2) begin sv[nv] = spikes; nv++; end
      @(posedge clk); #1;
    end
    step_valid = 1'b0; cfg_we = 1'b0;
    n_checks++;
    if (n_acc != 3 || nv != 2) begin n_fail++; $display("FAIL b2b_counts: acceptances %0d valids %0d expected 3 and 2", n_acc, nv); end
    n_checks++;
    if (acc_t[1] - acc_t[0] != 6) begin n_fail++; $display("FAIL b2b_gap1: got %0d expected 6", acc_t[1] - acc_t[0]); end
    n_checks++;
    if (acc_t[2] - acc_t[1] != 6) begin n_fail++; $display("FAIL b2b_gap2: got %0d expected 6", acc_t[2] - acc_t[1]); end
    n_checks++;
    if (sv[0] !== 4'b0001) begin n_fail++; $display("FAIL b2b_step1: got %b expected 0001", sv[0]); end
    n_checks++;
    if (sv[1] !== 4'b0001) begin n_fail++; $display("FAIL b2b_cfg_ignored: got %b expected 0001", sv[1]); end
  endtask

  task automatic test_reset_mid_run;
    int pulses = 0;
    do_reset();
    do_cfg(2'd0, 8'hFF, 5'd5);
    reset_mode = 1'b1;
    step_valid = 1'b1; inputs = 8'hFF;
    @(posedge clk); #1;
    step_valid = 1'b0;
    @(posedge clk); #1;
    mon_addr = 2'd0; #1;
    n_checks++;
    if (mon_membrane !== 6'd3) begin n_fail++; $display("FAIL mid_pre_mem0: got %0d expected 3", $signed(mon_membrane)); end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    reset_mode = 1'b0;
    n_checks++;
    if (step_ready !== 1'b1) begin n_fail++; $display("FAIL mid_ready: got %b expected 1", step_ready); end
    n_checks++;
    if (spikes !== 4'b0000) begin n_fail++; $display("FAIL mid_spikes: got %b expected 0000", spikes); end
    for (int j = 0; j < 4; j++) begin
      mon_addr = 2'(j); #1;
      n_checks++;
      if (mon_membrane !== 6'd0) begin n_fail++; $display("FAIL mid_mem%0d: got %0d expected 0", j, $signed(mon_membrane)); end
    end
    for (int c = 0; c < 10; c++) begin
      if (spikes_valid) pulses++;
      @(posedge clk); #1;
    end
    n_checks++;
    if (pulses != 0) begin n_fail++; $display("FAIL mid_no_valid: got %0d pulses expected 0", pulses); end
  endtask

  initial begin
    test_reset();
    test_basic_spike();
    test_cfg_same_edge();
    test_neg_saturation();
    test_decay();
    test_refractory_sub();
    test_back_to_back();
    test_reset_mid_run();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/lif_neuron_layer.md
# lif_neuron_layer

Time-multiplexed layer of `N_NEURONS` leaky integrate-and-fire neurons sharing one binary-weight synaptic datapath. Per-neuron weights, thresholds, membranes and refractory counters are held in registers. On each accepted input spike vector the block updates all neurons sequentially, one neuron per cycle, and returns a registered spike vector. It extends the single combinational neuron with state, refractory periods and selectable reset mode, and sits between the input spike source and the next layer or output logic.

## Interface
Parameters:
- `N_INPUTS`, 8: synapses per neuron. Must be a power of two.
- `N_NEURONS`, 4: neurons in the layer. Must be ≥ 2.
- `MEM_W`, 6: signed membrane width. Must be ≥ clog2(N_INPUTS)+2.
- `THR_W`, MEM_W-1: unsigned threshold width.
- `REF_W`, 3: refractory counter width.

Ports:
- `clk`  in  1  clock. All logic on rising edge.
- `reset`  in  1  synchronous, active-high.
- `cfg_we`  in  1  write weights and threshold of neuron `cfg_addr`.
- `cfg_addr`  in  clog2(N_NEURONS)  target neuron.
- `cfg_weights`  in  N_INPUTS  bit i: 1 means +1, 0 means -1.
- `cfg_threshold`  in  THR_W  spike threshold.
- `shift`  in  3  decay shift, global.
- `refractory`  in  REF_W  refractory steps after a spike, global.
- `reset_mode`  in  1  0: reset to zero; 1: subtract threshold.
- `step_valid`  in  1  input spike vector offered.
- `step_ready`  out  1  block can accept a step.
- `inputs`  in  N_INPUTS  input spike vector.
- `spikes_valid`  out  1  one-cycle pulse; `spikes` is new.
- `spikes`  out  N_NEURONS  registered spike vector, held until overwritten.
- `mon_addr`  in  clog2(N_NEURONS)  monitor select.
- `mon_membrane`  out  MEM_W  combinational read of membrane[`mon_addr`].

## Operation
- **FSM: IDLE → RUN → DONE → IDLE.**
  - IDLE: `step_ready`=1. When `step_valid` is high, latch `inputs`, set idx=0, go to RUN.
  - RUN: update neuron idx and write its spike bit into `spikes`. At idx==N_NEURONS-1, go to DONE; otherwise idx+1.
  - DONE: `spikes_valid`=1 for this cycle only, then go to IDLE.
- **Configuration writes:** a `cfg_we` write is applied only while `step_ready`=1 and is silently ignored otherwise.
- **`shift`, `refractory`, `reset_mode`:** sampled every RUN cycle. They must be held stable for the whole step.
- **Per-neuron update** (u = membrane, c = refractory count, th = zero-extended threshold):
  - psp = Σ over i with inputs[i]=1 of (w[i] ? +1 : −1). Range −N_INPUTS..+N_INPUTS, sign-extended to MEM_W.
  - d = u if shift==0, else u − (u >>> shift). Arithmetic shift, so it floors.
  - If c>0: u ← d, c ← c−1, spike=0. psp is ignored.
  - Else acc = saturating add of d and psp, clamped to [−2^(MEM_W−1), 2^(MEM_W−1)−1].
    - If acc ≥ th: spike=1, c ← `refractory`, u ← 0 (reset_mode 0) or acc−th (reset_mode 1, which cannot underflow).
    - Otherwise: spike=0, u ← acc.
- **Reset values:** all membranes 0, all c 0, all weights 0, all thresholds all-ones, `spikes`=0, `spikes_valid`=0, FSM in IDLE, so `step_ready`=1.
- **Reset during RUN:** the step is aborted and all state is cleared. `spikes_valid` does not pulse for the aborted step.

## Timing
- Step accepted at clock edge k. RUN occupies cycles k+1..k+N_NEURONS. `spikes_valid` is high in cycle k+N_NEURONS+1.
- Throughput: one step per N_NEURONS+2 cycles with `step_valid` held high.
- `step_ready` is low from the cycle after acceptance through DONE.
- `spikes` bit j updates at the end of RUN cycle j. Partial vectors are visible before DONE; only the value at `spikes_valid` is defined.
- A `cfg_we` write in IDLE takes effect for the next accepted step, including a step accepted on the same edge.

## Structure
- Shared package `lif_pkg`: FSM state encoding, weight polarity constants (W_POS=1, W_NEG=0), reset-mode constants.
- One combinational sub-module `lif_neuron_core`:
  - Inputs: u, c, weights, inputs, threshold, shift, refractory, reset_mode.
  - Outputs: next u, next c, spike.
  - Internally: the popcount adder, the decay shifter and the saturating adder.
- The top level holds the FSM, the register arrays, the idx counter and the config and monitor muxing.

## Test plan
All scenarios use the defaults (N_INPUTS=8, N_NEURONS=4, MEM_W=6), shift=0, refractory=0, reset_mode=0 unless stated.
- **Basic spike:** neuron0 weights 0xFF, thr 5, inputs 0xFF, one step → `spikes_valid` 5 cycles after acceptance, spikes[0]=1, others 0 (thresholds 31), mon_membrane[0]=0.
- **Negative saturation:** neuron1 weights 0x00, thr 31, inputs 0xFF, 5 steps → membrane −8, −16, −24, −32, −32, never spikes.
- **Decay:** neuron2 charged to 16 (weights 0xFF, thr 31, inputs 0xFF, 2 steps). Then shift=1, inputs 0 for 5 steps → membrane 8, 4, 2, 1, 1.
- **Refractory with subtract reset:** neuron0 thr 5, weights 0xFF, inputs 0xFF, refractory 2, reset_mode 1, 4 steps → spikes[0] = 1, 0, 0, 1; membrane 3, 3, 3, 6.
- **Handshake:** `step_valid` held high continuously → acceptances exactly 6 cycles apart. A `cfg_we` during RUN has no effect on later results.
- **Reset mid-operation:** `reset` asserted in the second RUN cycle → no `spikes_valid` pulse, `step_ready`=1 in the next cycle, all mon_membrane 0, `spikes`=0.
